uart_frame_loader: RTL and testbench

//  Command parser between the UART receiver and the LED panel driver: turns the received byte stream into writes to the panel's frame buffer.

---
 rtl/panel_pkg.sv | 21 ++
 rtl/uart_frame_loader_if.sv | 33 +++
 rtl/frame_shadow_buf.sv | 32 +++
 rtl/uart_frame_loader.sv | 201 ++++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - command constants, frame-buffer geometry and parser states shared by the panel blocks
package panel_pkg;

    localparam int          FB_COLS   = 16;
    localparam int          COL_AW    = $clog2(FB_COLS);

    localparam logic [7:0]  CMD_FRAME = 8'hA5;
    localparam logic [3:0]  CMD_COL   = 4'hB;
    localparam logic [4:0]  CMD_RGB   = 5'b11000;

    localparam logic [2:0]  RGB_RESET = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FRAME_DATA = 3'd1,
        ST_FRAME_CSUM = 3'd2,
        ST_COMMIT     = 3'd3,
        ST_COL_DATA   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_frame_loader_if.sv
// rtl/uart_frame_loader_if.sv - byte stream in, frame-buffer/colour writes out
// Signals:
//   rx_dv, rx_byte      : received byte strobe and data (UART side drives)
//   fb_we/fb_addr/fb_data : frame-buffer column write
//   rgb, rgb_we         : draw colour and its update strobe
//   frame_ok, pkt_err   : frame committed / packet rejected pulses
//   busy                : parser not idle
// Modports: master = UART/bench side, slave = loader side.
interface uart_frame_loader_if;
    import panel_pkg::*;

    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              fb_we;
    logic [COL_AW-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic [2:0]        rgb;
    logic              rgb_we;
    logic              frame_ok;
    logic              pkt_err;
    logic              busy;

    modport master (
        output rx_dv, rx_byte,
        input  fb_we, fb_addr, fb_data, rgb, rgb_we, frame_ok, pkt_err, busy
    );

    modport slave (
        input  rx_dv, rx_byte,
        output fb_we, fb_addr, fb_data, rgb, rgb_we, frame_ok, pkt_err, busy
    );

endinterface

// File: rtl/frame_shadow_buf.sv
// rtl/frame_shadow_buf.sv - 16x8 shadow register file holding a frame until its checksum is verified
// Ports:
//   clk, reset        : clock, async active-low reset (clears all columns)
//   i_we/i_waddr/i_wdata : parser write port
//   i_raddr, o_rdata  : combinational read port driven by the commit counter
module frame_shadow_buf
    import panel_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [COL_AW-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [COL_AW-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [FB_COLS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FB_COLS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - parses UART command bytes into frame-buffer writes and colour updates
// Ports:
//   clk   : system clock
//   reset : async active-low reset
//   bus   : uart_frame_loader_if.slave (rx byte in; fb/rgb/status out, all registered)
module uart_frame_loader
    import panel_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_frame_loader_if.slave    bus
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e            r_state;
    logic [3:0]        r_idx;
    logic [7:0]        r_csum;
    logic [COL_AW-1:0] r_col;
    logic [TW-1:0]     r_tmo;
    logic              r_pend_v;
    logic [7:0]        r_pend_byte;
    // Bit 4 marks the cycle after the last column write, where frame_ok fires.
    logic [4:0]        r_commit_cnt;

    logic              r_fb_we;
    logic [COL_AW-1:0] r_fb_addr;
    logic [7:0]        r_fb_data;
    logic [2:0]        r_rgb;
    logic              r_rgb_we;
    logic              r_frame_ok;
    logic              r_pkt_err;
    logic              r_busy;

    logic              w_dv;
    logic [7:0]        w_byte;
    logic              w_tmo_state;
    logic              w_timeout;
    logic              w_sh_we;
    logic [7:0]        w_sh_rdata;

    // A byte parked during COMMIT takes priority in IDLE; the pending flag is only
    // ever set in COMMIT, so outside IDLE these equal the live rx inputs.
    assign w_dv        = bus.rx_dv | r_pend_v;
    assign w_byte      = r_pend_v ? r_pend_byte : bus.rx_byte;

    assign w_tmo_state = (r_state == ST_FRAME_DATA) || (r_state == ST_FRAME_CSUM) ||
                         (r_state == ST_COL_DATA);
    assign w_timeout   = w_tmo_state && !bus.rx_dv && (r_tmo == TMO_LAST);

    assign w_sh_we     = (r_state == ST_FRAME_DATA) && bus.rx_dv;

    frame_shadow_buf u_shadow (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_sh_we),
        .i_waddr (r_idx),
        .i_wdata (bus.rx_byte),
        .i_raddr (r_commit_cnt[3:0]),
        .o_rdata (w_sh_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_csum       <= '0;
            r_col        <= '0;
            r_tmo        <= '0;
            r_pend_v     <= 1'b0;
            r_pend_byte  <= '0;
            r_commit_cnt <= '0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_rgb        <= RGB_RESET;
            r_rgb_we     <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_fb_we    <= 1'b0;
            r_rgb_we   <= 1'b0;
            r_frame_ok <= 1'b0;
            r_pkt_err  <= 1'b0;

            if (bus.rx_dv || !w_tmo_state) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_dv) begin
                        r_pend_v <= 1'b0;
                        if (w_byte == CMD_FRAME) begin
                            r_state <= ST_FRAME_DATA;
                            r_busy  <= 1'b1;
                        end else if (w_byte[7:4] == CMD_COL) begin
                            r_col   <= w_byte[3:0];
                            r_state <= ST_COL_DATA;
                            r_busy  <= 1'b1;
                        end else if (w_byte[7:3] == CMD_RGB) begin
                            r_rgb    <= w_byte[2:0];
                            r_rgb_we <= 1'b1;
                        end else begin
                            r_pkt_err <= 1'b1;
                        end
                    end
                end

                ST_FRAME_DATA: begin
                    if (w_timeout) begin
                        r_pkt_err <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_idx     <= '0;
                        r_csum    <= '0;
                    end else if (bus.rx_dv) begin
                        r_csum <= r_csum ^ bus.rx_byte;
                        r_idx  <= r_idx + 1'b1;
                        if (r_idx == 4'd15) begin
                            r_state <= ST_FRAME_CSUM;
                        end
                    end
                end

                ST_FRAME_CSUM: begin
                    if (w_timeout) begin
                        r_pkt_err <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_idx     <= '0;
                        r_csum    <= '0;
                    end else if (bus.rx_dv) begin
                        r_idx  <= '0;
                        r_csum <= '0;
                        if (bus.rx_byte == r_csum) begin
                            r_state      <= ST_COMMIT;
                            r_commit_cnt <= '0;
                        end else begin
                            r_pkt_err <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                        end
                    end
                end

                ST_COMMIT: begin
                    if (bus.rx_dv) begin
                        r_pend_v    <= 1'b1;
                        r_pend_byte <= bus.rx_byte;
                    end
                    if (r_commit_cnt[4]) begin
                        r_frame_ok <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end else begin
                        r_fb_we      <= 1'b1;
                        r_fb_addr    <= r_commit_cnt[3:0];
                        r_fb_data    <= w_sh_rdata;
                        r_commit_cnt <= r_commit_cnt + 1'b1;
                    end
                end

                ST_COL_DATA: begin
                    if (w_timeout) begin
                        r_pkt_err <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else if (bus.rx_dv) begin
                        r_fb_we   <= 1'b1;
                        r_fb_addr <= r_col;
                        r_fb_data <= bus.rx_byte;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fb_we    = r_fb_we;
    assign bus.fb_addr  = r_fb_addr;
    assign bus.fb_data  = r_fb_data;
    assign bus.rgb      = r_rgb;
    assign bus.rgb_we   = r_rgb_we;
    assign bus.frame_ok = r_frame_ok;
    assign bus.pkt_err  = r_pkt_err;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - scoreboard bench for uart_frame_loader
module tb_uart_frame_loader;

    localparam logic [3:0] K_WR  = 4'h1;
    localparam logic [3:0] K_FOK = 4'h2;
    localparam logic [3:0] K_ERR = 4'h3;
    localparam logic [3:0] K_RGB = 4'h4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_dv_cyc = 0;
    int   err_cyc = 0;
    bit   mon_en = 1'b1;

    logic [15:0] exp_q[$];

    uart_frame_loader_if bus();

    uart_frame_loader #(.TIMEOUT_CYCLES(1000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ev(input logic [3:0] k, input logic [3:0] a, input logic [7:0] d);
        return {k, a, d};
    endfunction

    task automatic score(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({"unexpected_", tag}, {16'h0, obs}, 32'h0000_FFFF);
        end else begin
            e = exp_q.pop_front();
            check(tag, {16'h0, obs}, {16'h0, e});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (bus.fb_we)    score("fb_write", ev(K_WR, bus.fb_addr, bus.fb_data));
            if (bus.frame_ok) score("frame_ok", ev(K_FOK, 4'h0, 8'h00));
            if (bus.pkt_err) begin
                err_cyc = cyc;
                score("pkt_err", ev(K_ERR, 4'h0, 8'h00));
            end
            if (bus.rgb_we)   score("rgb_we", ev(K_RGB, 4'h0, {5'b0, bus.rgb}));
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        bus.rx_dv   = 1'b1;
        bus.rx_byte = b;
        @(posedge clk);
        #1;
        last_dv_cyc = cyc;
        bus.rx_dv   = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_wr(input string tag, input logic [3:0] addr, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.fb_we && bus.fb_addr == addr) found = 1'b1;
        end
        check(tag, {31'b0, found}, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] d[16], input logic [7:0] cs);
        send_byte(8'hA5, 2);
        for (int i = 0; i < 16; i++) send_byte(d[i], 2);
        send_byte(cs, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d[16];
        logic [7:0] cs;

        bus.rx_dv   = 1'b0;
        bus.rx_byte = 8'h00;

        // Reset values, then a long idle with no traffic.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", {29'b0, bus.rgb}, 32'h5);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_strobes", {28'b0, bus.fb_we, bus.rgb_we, bus.frame_ok, bus.pkt_err}, 32'h0);
        reset = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        check("idle_rgb", {29'b0, bus.rgb}, 32'h5);
        check("idle_busy", {31'b0, bus.busy}, 32'h0);

        // Good frame 00..0F, checksum 00.
        for (int i = 0; i < 16; i++) begin
            d[i] = 8'(i);
            exp_q.push_back(ev(K_WR, 4'(i), 8'(i)));
        end
        exp_q.push_back(ev(K_FOK, 4'h0, 8'h00));
        send_byte(8'hA5, 1);
        check("busy_in_frame", {31'b0, bus.busy}, 32'h1);
        for (int i = 0; i < 16; i++) send_byte(d[i], 2);
        send_byte(8'h00, 0);
        wait_drain("frame1_drain", 100);
        check("frame1_busy", {31'b0, bus.busy}, 32'h0);

        // Bad checksum: 16x FF xors to 00, send 01.
        for (int i = 0; i < 16; i++) d[i] = 8'hFF;
        exp_q.push_back(ev(K_ERR, 4'h0, 8'h00));
        send_frame(d, 8'h01);
        wait_drain("badcs_drain", 50);
        exp_q.push_back(ev(K_RGB, 4'h0, 8'h02));
        send_byte(8'hC2, 2);
        wait_drain("rgb2_drain", 20);
        check("rgb2_val", {29'b0, bus.rgb}, 32'h2);

        // Single column write.
        exp_q.push_back(ev(K_WR, 4'h7, 8'h3C));
        send_byte(8'hB7, 2);
        send_byte(8'h3C, 0);
        wait_drain("col7_drain", 20);
        check("col7_busy", {31'b0, bus.busy}, 32'h0);

        // Unknown command byte.
        exp_q.push_back(ev(K_ERR, 4'h0, 8'h00));
        send_byte(8'h12, 0);
        wait_drain("unknown_drain", 20);

        // Timeout after 5 data bytes.
        exp_q.push_back(ev(K_ERR, 4'h0, 8'h00));
        send_byte(8'hA5, 2);
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), (i == 4) ? 0 : 2);
        wait_drain("tmo_drain", 1100);
        check("tmo_latency", err_cyc - last_dv_cyc, 32'd1000);
        check("tmo_busy", {31'b0, bus.busy}, 32'h0);
        repeat (200) @(posedge clk);
        exp_q.push_back(ev(K_WR, 4'h0, 8'h81));
        send_byte(8'hB0, 2);
        send_byte(8'h81, 0);
        wait_drain("col0_drain", 20);

        // Frame with a colour byte arriving mid-COMMIT.
        cs = 8'h00;
        for (int i = 0; i < 16; i++) begin
            d[i] = 8'((i * 17) ^ 8'h5A);
            cs   = cs ^ d[i];
            exp_q.push_back(ev(K_WR, 4'(i), d[i]));
        end
        exp_q.push_back(ev(K_FOK, 4'h0, 8'h00));
        exp_q.push_back(ev(K_RGB, 4'h0, 8'h06));
        send_frame(d, cs);
        wait_wr("inj_wait", 4'h1, 20);
        bus.rx_dv   = 1'b1;
        bus.rx_byte = 8'hC6;
        @(posedge clk);
        #1;
        bus.rx_dv   = 1'b0;
        wait_drain("inj_drain", 100);
        check("inj_rgb", {29'b0, bus.rgb}, 32'h6);

        // Reset pulled in the middle of COMMIT.
        mon_en = 1'b0;
        send_frame(d, cs);
        wait_wr("rstmid_wait", 4'h4, 20);
        reset = 1'b0;
        #1;
        check("rstmid_fb_we", {31'b0, bus.fb_we}, 32'h0);
        check("rstmid_busy", {31'b0, bus.busy}, 32'h0);
        check("rstmid_rgb", {29'b0, bus.rgb}, 32'h5);
        check("rstmid_addr", {28'b0, bus.fb_addr}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("post_rst_busy", {31'b0, bus.busy}, 32'h0);
        check("post_rst_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
